// File: rtl/lru_nway.sv
// rtl/lru_nway.sv - true-LRU age-permutation tracker for an N-way, S-set cache with registered victim query
// Optional feature: define LRU_LOCK_EN to add lock_mask[WAYS-1:0] excluding ways from victim choice.
module lru_nway #(
    parameter  int WAYS = 4,
    parameter  int SETS = 4,
    localparam int AW   = $clog2(WAYS),
    localparam int SW   = (SETS > 1) ? $clog2(SETS) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          acc_valid,
    input  logic [SW-1:0] acc_set,
    input  logic [AW-1:0] acc_way,
    input  logic          acc_hit,
    input  logic          inv_valid,
    input  logic [SW-1:0] inv_set,
    input  logic [AW-1:0] inv_way,
    output logic          inv_busy,
`ifdef LRU_LOCK_EN
    input  logic [WAYS-1:0] lock_mask,
`endif
    input  logic          qry_valid,
    input  logic [SW-1:0] qry_set,
    output logic          vic_valid,
    output logic [AW-1:0] vic_way,
    output logic          vic_none
);

    localparam logic [AW-1:0] AGE_MRU = AW'(WAYS - 1);

    logic [AW-1:0]   age   [SETS][WAYS];
    logic [WAYS-1:0] valid [SETS];

    logic            acc_fire;
    logic            inv_fire;
    logic [AW-1:0]   acc_age;
    logic [AW-1:0]   inv_age;
    logic [WAYS-1:0] excl;
    logic [WAYS-1:0] qry_valid_bits;
    logic [AW-1:0]   best_age;
    logic [AW-1:0]   vic_way_c;
    logic            found;

    // Same-set collisions are refused so the two permutation updates never interleave.
    assign acc_fire = enable & acc_valid;
    assign inv_busy = inv_valid & acc_valid & enable & (inv_set == acc_set);
    assign inv_fire = enable & inv_valid & ~inv_busy;

    assign acc_age = age[acc_set][acc_way];
    assign inv_age = age[inv_set][inv_way];

`ifdef LRU_LOCK_EN
    assign excl = lock_mask;
`else
    assign excl = '0;
`endif

    assign qry_valid_bits = valid[qry_set];

    // Prefer the lowest-index eligible invalid way; otherwise the eligible way with the smallest age.
    always_comb begin
        vic_way_c = '0;
        best_age  = '0;
        found     = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!found && !qry_valid_bits[w] && !excl[w]) begin
                vic_way_c = AW'(w);
                found     = 1'b1;
            end
        end
        if (!found) begin
            for (int w = 0; w < WAYS; w++) begin
                if (!excl[w] && (!found || age[qry_set][w] < best_age)) begin
                    best_age  = age[qry_set][w];
                    vic_way_c = AW'(w);
                    found     = 1'b1;
                end
            end
        end
        if (!found) begin
            vic_way_c = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    age[s][w] <= AW'(w);
                end
                valid[s] <= '0;
            end
            vic_valid <= 1'b0;
            vic_way   <= '0;
        end else begin
            if (acc_fire) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (AW'(w) == acc_way) begin
                        age[acc_set][w] <= AGE_MRU;
                    end else if (age[acc_set][w] > acc_age) begin
                        age[acc_set][w] <= age[acc_set][w] - AW'(1);
                    end
                end
                if (!acc_hit) begin
                    valid[acc_set][acc_way] <= 1'b1;
                end
            end
            if (inv_fire) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (AW'(w) == inv_way) begin
                        age[inv_set][w] <= '0;
                    end else if (age[inv_set][w] < inv_age) begin
                        age[inv_set][w] <= age[inv_set][w] + AW'(1);
                    end
                end
                valid[inv_set][inv_way] <= 1'b0;
            end
            vic_valid <= qry_valid;
            if (qry_valid) begin
                vic_way <= vic_way_c;
            end
        end
    end

`ifdef LRU_LOCK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            vic_none <= 1'b0;
        end else if (qry_valid) begin
            vic_none <= ~found;
        end
    end
`else
    assign vic_none = 1'b0;
`endif

endmodule
